// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants and register-file types
package cpu_pkg;

   localparam int DATA_W     = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   // XZR: reads as zero, writes are discarded
   localparam reg_addr_t XZR_IDX = reg_addr_t'(31);

endpackage

// File: rtl/regfile_32x64_if.sv
// rtl/regfile_32x64_if.sv - register file read/write port bundle
interface regfile_32x64_if;
   import cpu_pkg::*;

   logic      RegWrite;
   reg_addr_t WriteRegister;
   data_t     WriteData;
   reg_addr_t ReadRegister1;
   reg_addr_t ReadRegister2;
   data_t     ReadData1;
   data_t     ReadData2;

   // pipeline side: drives WB write and ID read addresses
   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2
   );

   // register file side
   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );

endinterface

// File: rtl/dec5x32.sv
// rtl/dec5x32.sv - 5:32 one-hot decoder with enable
module dec5x32 (
   input  logic [4:0]  in,
   input  logic        en,
   output logic [31:0] out
);

   // exactly one bit set when enabled, none otherwise
   assign out = en ? (32'd1 << in) : 32'd0;

endmodule

// File: rtl/regfile_read_mux.sv
// rtl/regfile_read_mux.sv - NUM_REGS:1 register read multiplexer
module regfile_read_mux
   import cpu_pkg::*;
(
   input  data_t     din [NUM_REGS],
   input  reg_addr_t sel,
   output data_t     dout
);

   // pure combinational select; the XZR input is tied to zero by the caller
   assign dout = din[sel];

endmodule

// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - 32x64 integer register file, XZR hard-wired, optional REGFILE_BYPASS_EN forwarding
module regfile_32x64
   import cpu_pkg::*;
(
   input logic            clk,
   input logic            reset_n,
   regfile_32x64_if.slave rf
);

   logic [NUM_REGS-1:0] we;
   data_t               regs [NUM_REGS];
   data_t               mux1;
   data_t               mux2;

   dec5x32 u_dec (
      .in  (rf.WriteRegister),
      .en  (rf.RegWrite),
      .out (we)
   );

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i == int'(XZR_IDX)) begin : g_zr
         logic unused_we_zr;
         assign unused_we_zr = we[i];
         assign regs[i]      = '0;
      end else begin : g_ff
         data_t q;
         // storage flop: sync clear wins over any write in the same cycle
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               q <= '0;
            end else if (we[i]) begin
               q <= rf.WriteData;
            end
         end
         assign regs[i] = q;
      end
   end

   regfile_read_mux u_mux1 (
      .din  (regs),
      .sel  (rf.ReadRegister1),
      .dout (mux1)
   );

   regfile_read_mux u_mux2 (
      .din  (regs),
      .sel  (rf.ReadRegister2),
      .dout (mux2)
   );

`ifdef REGFILE_BYPASS_EN
   logic wr_live;

   // a write that will land this edge, excluding XZR and reset cycles
   assign wr_live = reset_n && rf.RegWrite && (rf.WriteRegister != XZR_IDX);

   // forward WB data straight to ID when addresses match
   assign rf.ReadData1 = (wr_live && (rf.ReadRegister1 == rf.WriteRegister)) ? rf.WriteData : mux1;
   assign rf.ReadData2 = (wr_live && (rf.ReadRegister2 == rf.WriteRegister)) ? rf.WriteData : mux2;
`else
   // no forwarding: same-cycle reads see pre-write contents
   assign rf.ReadData1 = mux1;
   assign rf.ReadData2 = mux2;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// tb/tb_regfile_32x64.sv - scoreboard bench for regfile_32x64
module tb_regfile_32x64;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sample = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   regfile_32x64_if rf();

   regfile_32x64 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rf      (rf)
   );

   typedef struct {
      string name;
      data_t e1;
      data_t e2;
   } exp_t;

   exp_t  sb [$];
   data_t model [NUM_REGS];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // monitor: pops expectations and compares while sample is raised
   always @(negedge clk) begin
      if (sample) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: sample raised with no expectation queued");
         end else begin
            e = sb.pop_front();
            n_cmp++;
            if (rf.ReadData1 !== e.e1) begin
               n_bad++;
               $display("FAIL %s port1: got %h expected %h", e.name, rf.ReadData1, e.e1);
            end
            n_cmp++;
            if (rf.ReadData2 !== e.e2) begin
               n_bad++;
               $display("FAIL %s port2: got %h expected %h", e.name, rf.ReadData2, e.e2);
            end
         end
      end
   end

   task automatic wr(input reg_addr_t a, input data_t d);
      @(posedge clk);
      #1;
      rf.RegWrite      = 1'b1;
      rf.WriteRegister = a;
      rf.WriteData     = d;
      if (a != XZR_IDX) model[a] = d;
   endtask

   task automatic rd(input string nm, input reg_addr_t a1, input reg_addr_t a2,
                     input data_t e1, input data_t e2);
      @(posedge clk);
      #1;
      rf.RegWrite      = 1'b0;
      rf.ReadRegister1 = a1;
      rf.ReadRegister2 = a2;
      sb.push_back('{nm, e1, e2});
      sample = 1'b1;
      @(negedge clk);
      #1;
      sample = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      rf.RegWrite      = 1'b1;
      rf.WriteRegister = 5'd4;
      rf.WriteData     = 64'h5555;
      rf.ReadRegister1 = '0;
      rf.ReadRegister2 = '0;

      // 1: reset, then every index reads zero on both ports
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      rf.RegWrite = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rd("reset_all", reg_addr_t'(i), reg_addr_t'(NUM_REGS-1-i), 64'h0, 64'h0);

      // 2: two writes, distinct and same-address reads
      wr(5'd5, 64'hDEAD_BEEF_0123_4567);
      wr(5'd10, 64'h1);
      rd("rd_5_10", 5'd5, 5'd10, 64'hDEAD_BEEF_0123_4567, 64'h1);
      rd("rd_5_5", 5'd5, 5'd5, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);

      // 3: write to XZR is discarded, nothing else disturbed
      wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
      rd("xzr_read", 5'd31, 5'd31, 64'h0, 64'h0);
      for (int i = 0; i < NUM_REGS - 1; i++)
         rd("after_xzr", reg_addr_t'(i), 5'd31,
            (i == 5) ? 64'hDEAD_BEEF_0123_4567 : (i == 10) ? 64'h1 : 64'h0, 64'h0);

      // 4: RegWrite low leaves register untouched
      @(posedge clk);
      #1;
      rf.RegWrite      = 1'b0;
      rf.WriteRegister = 5'd7;
      rf.WriteData     = 64'hAA;
      rd("no_write_7", 5'd7, 5'd10, 64'h0, 64'h1);

      // 5: same-cycle write/read, with and without forwarding
      wr(5'd3, 64'h11);
      @(posedge clk);
      #1;
      rf.RegWrite      = 1'b1;
      rf.WriteRegister = 5'd3;
      rf.WriteData     = 64'h22;
      rf.ReadRegister1 = 5'd3;
      rf.ReadRegister2 = 5'd10;
      sb.push_back('{"same_cycle", BYP ? 64'h22 : 64'h11, 64'h1});
      sample = 1'b1;
      @(negedge clk);
      #1;
      sample = 1'b0;
      model[3] = 64'h22;
      rd("after_edge_3", 5'd3, 5'd3, 64'h22, 64'h22);

      // same-cycle write to XZR never forwards
      @(posedge clk);
      #1;
      rf.RegWrite      = 1'b1;
      rf.WriteRegister = 5'd31;
      rf.WriteData     = 64'h77;
      rf.ReadRegister1 = 5'd31;
      rf.ReadRegister2 = 5'd3;
      sb.push_back('{"same_cycle_xzr", 64'h0, 64'h22});
      sample = 1'b1;
      @(negedge clk);
      #1;
      sample = 1'b0;

      // 6: fill X0..X30, check, then reset with a pending write
      for (int i = 0; i < NUM_REGS - 1; i++) wr(reg_addr_t'(i), data_t'(i) * 64'h0101);
      rd("fill_0_30", 5'd0, 5'd30, 64'h0, 64'h1E1E);
      rd("fill_4_17", 5'd4, 5'd17, 64'h0404, 64'h1111);
      @(posedge clk);
      #1;
      reset_n          = 1'b0;
      rf.RegWrite      = 1'b1;
      rf.WriteRegister = 5'd4;
      rf.WriteData     = 64'h99;
      rf.ReadRegister1 = 5'd4;
      rf.ReadRegister2 = 5'd31;
      @(posedge clk);
      #1;
      reset_n     = 1'b1;
      rf.RegWrite = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rd("mid_reset", reg_addr_t'(i), reg_addr_t'(i), 64'h0, 64'h0);

      // drain bound
      repeat (5) @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
